cdb_scheduler: RTL and testbench
================================

# cdb_scheduler

Registered two-level round-robin scheduler granting the common data bus (CDB) to one of 16 functional-unit requesters per cycle. It uses the same 4-group × 4-requester topology as the combinational arbitration tree, and adds rotating priority per group and at the base level, a one-cycle registered grant, and stall handling. It sits between the functional-unit result buffers and the CDB write-back mux in the out-of-order core.

## Interface
- NUM_REQ, 16, number of requesters; fixed at 16.
- GROUP_SIZE, 4, requesters per group; fixed at 4.
- clock_IN  input  1  single clock; all state updates on the rising edge.
- reset_n_IN  input  1  reset; asynchronous, active-low.
- requests_IN  input  16  one bit per functional unit; high = result ready for broadcast.
- stall_IN  input  1  CDB consumer cannot accept; freezes the current grant and all pointers.
- grants_OUT  output  16  registered one-hot grant; all zeros when idle.
- grant_valid_OUT  output  1  registered; high when grants_OUT is non-zero.
- grant_index_OUT  output  4  registered binary index of the granted requester; 0 when idle.

## Operation
- State:
  - group_ptr[1:0]: base-level priority start.
  - local_ptr[g][1:0] for g = 0..3: priority start within group g.
  - The three output registers.
- Effective requests: eff = requests_IN & ~grants_OUT. The requester currently holding the grant is excluded from the next arbitration.
- Group request: group_req[g] = OR of eff[4g+3:4g].
- Base pick: the first g with group_req[g] set, searching g = group_ptr, group_ptr+1, … mod 4.
- Local pick inside the selected group: the first j with eff[4g+j] set, searching j = local_ptr[g], +1, … mod 4.
- Winner index: i = 4g + j.
- Clock edge with stall_IN = 0 and any eff bit set:
  - grants_OUT ← one-hot(i); grant_index_OUT ← i; grant_valid_OUT ← 1.
  - local_ptr[g] ← (j+1) mod 4; group_ptr ← (g+1) mod 4.
  - All other local pointers are unchanged.
- Clock edge with stall_IN = 0 and eff = 0: outputs go to zero/idle; pointers are unchanged.
- Clock edge with stall_IN = 1: outputs and all pointers hold their values.
  - This applies even if the granted requester drops its request. That requester must keep its result stable until a non-stalled cycle ends its grant.
- Fairness: a requester that holds its request continuously is granted within 16 non-stalled grant cycles.

## Timing
- Latency: requests sampled at edge N produce a grant visible after edge N. There is no combinational path from requests_IN to any output.
- A grant lasts exactly one cycle, plus any number of cycles during which stall_IN is high.
- Back-to-back operation: a lone persistent requester is granted every other cycle, because the masking rule excludes it while its grant is visible. Two or more persistent requesters yield a grant every cycle.
- Reset (asynchronous assert): grants_OUT = 0, grant_valid_OUT = 0, grant_index_OUT = 0, group_ptr = 0, all local_ptr = 0.
  - Initial priority order is therefore index 0 first.
  - Reset asserted mid-grant or mid-stall clears everything immediately.
  - Arbitration resumes on the first edge after deassertion.
- Wrap-around: granting index 15 sets group_ptr = 0 and local_ptr[3] = 0.
- stall_IN is don't-care while grant_valid_OUT = 0, except that it still blocks any new grant on that edge.

## Structure
- Shared package cdb_pkg: NUM_REQ, GROUP_SIZE, NUM_GROUPS = 4, and the index width of 4.
- Sub-module rr_arbiter4 holds the combinational search for one round-robin level:
  - Inputs: 4 requests, a 2-bit pointer.
  - Outputs: one-hot grant, 2-bit index, any.
  - Instantiated four times for the groups and once for the base level.
- The top level holds all registers, the request masking, and the pointer-update logic.

## Test plan
- Reset then idle: reset_n_IN low with requests_IN = 16'hFFFF → all outputs 0. After release with requests_IN = 0 → outputs stay 0 and pointers stay 0.
- Full contention: requests_IN = 16'hFFFF held for 16 cycles → grant_index_OUT sequence 0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15, then wraps to 0.
- Lone persistent requester: requests_IN = 16'h0020 held → grant_index_OUT = 5 with grant_valid_OUT alternating 1, 0, 1, 0.
- Stall hold: grant on index 3, then stall_IN high for 3 cycles while requests_IN changes to 16'h8000 → grants_OUT stays 16'h0008 for all stalled cycles. On the first non-stalled edge → grant moves to index 15.
- Group-local rotation: requests_IN = 16'h0003 held → grants alternate between index 0 and index 1 every cycle, with group_ptr rotating past empty groups.
- Async reset mid-stall: grant active with stall_IN high, pulse reset_n_IN low between edges → outputs clear immediately without waiting for a clock edge. After release with 16'hFFFF → first grant is index 0.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared sizing constants for the CDB write-back scheduler.
// 16 requesters arranged as 4 groups of 4, 4-bit winner index.
package cdb_pkg;

    localparam int NUM_REQ    = 16;
    localparam int GROUP_SIZE = 4;
    localparam int NUM_GROUPS = 4;
    localparam int IDX_W      = 4;
    localparam int GRP_W      = 2;

endpackage

// File: rtl/rr_arbiter4.sv
// One 4-way round-robin search level (combinational).
// Ports: i_req[3:0], i_ptr[1:0] in; o_gnt one-hot, o_idx, o_any out.
module rr_arbiter4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_gnt,
    output logic [1:0] o_idx,
    output logic       o_any
);

    logic [1:0] w_idx;

    // Walk from farthest to nearest slot so the slot at i_ptr,
    // visited last, has the highest priority.
    always_comb begin
        o_idx = '0;
        w_idx = '0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = i_ptr + 2'(k);
            if (i_req[w_idx]) begin
                o_idx = w_idx;
            end
        end
    end

    assign o_any = |i_req;

    always_comb begin
        o_gnt = '0;
        if (o_any) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_scheduler.sv
// Registered two-level round-robin CDB grant over 16 requesters.
// Ports: clock_IN, reset_n_IN, requests_IN[15:0], stall_IN in;
// grants_OUT[15:0], grant_valid_OUT, grant_index_OUT[3:0] out.
module cdb_scheduler
    import cdb_pkg::*;
(
    input  logic               clock_IN,
    input  logic               reset_n_IN,
    input  logic [NUM_REQ-1:0] requests_IN,
    input  logic               stall_IN,
    output logic [NUM_REQ-1:0] grants_OUT,
    output logic               grant_valid_OUT,
    output logic [IDX_W-1:0]   grant_index_OUT
);

    logic [GRP_W-1:0]      r_group_ptr;
    logic [GRP_W-1:0]      r_local_ptr [NUM_GROUPS];

    logic [NUM_REQ-1:0]    w_eff;
    logic [NUM_GROUPS-1:0] w_grp_req;
    logic [3:0]            w_loc_gnt [NUM_GROUPS];
    logic [GRP_W-1:0]      w_loc_idx [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] w_base_gnt;
    logic [GRP_W-1:0]      w_base_idx;
    logic                  w_any;
    logic [GRP_W-1:0]      w_sel_j;
    logic [IDX_W-1:0]      w_win_idx;
    logic [NUM_REQ-1:0]    w_next_grant;

    // The current holder sits out the next arbitration.
    assign w_eff = requests_IN & ~grants_OUT;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
        rr_arbiter4 u_grp (
            .i_req (w_eff[GROUP_SIZE*g +: GROUP_SIZE]),
            .i_ptr (r_local_ptr[g]),
            .o_gnt (w_loc_gnt[g]),
            .o_idx (w_loc_idx[g]),
            .o_any (w_grp_req[g])
        );
        assign w_next_grant[GROUP_SIZE*g +: GROUP_SIZE] =
            w_loc_gnt[g] & {GROUP_SIZE{w_base_gnt[g]}};
    end

    rr_arbiter4 u_base (
        .i_req (w_grp_req),
        .i_ptr (r_group_ptr),
        .o_gnt (w_base_gnt),
        .o_idx (w_base_idx),
        .o_any (w_any)
    );

    assign w_sel_j   = w_loc_idx[w_base_idx];
    assign w_win_idx = {w_base_idx, w_sel_j};

    always_ff @(posedge clock_IN or negedge reset_n_IN) begin
        if (!reset_n_IN) begin
            grants_OUT      <= '0;
            grant_valid_OUT <= 1'b0;
            grant_index_OUT <= '0;
            r_group_ptr     <= '0;
            for (int g = 0; g < NUM_GROUPS; g++) begin
                r_local_ptr[g] <= '0;
            end
        end else if (!stall_IN) begin
            if (w_any) begin
                grants_OUT              <= w_next_grant;
                grant_valid_OUT         <= 1'b1;
                grant_index_OUT         <= w_win_idx;
                r_local_ptr[w_base_idx] <= w_sel_j + 2'd1;
                r_group_ptr             <= w_base_idx + 2'd1;
            end else begin
                grants_OUT      <= '0;
                grant_valid_OUT <= 1'b0;
                grant_index_OUT <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Directed self-checking bench for cdb_scheduler.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cdb_scheduler;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        stall;
    logic [15:0] gnt;
    logic        gv;
    logic [3:0]  gidx;

    int total = 0;
    int bad   = 0;

    cdb_scheduler dut (
        .clock_IN        (clk),
        .reset_n_IN      (rst_n),
        .requests_IN     (req),
        .stall_IN        (stall),
        .grants_OUT      (gnt),
        .grant_valid_OUT (gv),
        .grant_index_OUT (gidx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check a full expected grant from the winner index.
    task automatic chk_grant(input string tag, input int idx);
        logic [15:0] oh;
        oh = 16'h0001 << idx;
        chk({tag, "_gnt"}, 32'(gnt), 32'(oh));
        chk({tag, "_vld"}, 32'(gv), 32'd1);
        chk({tag, "_idx"}, 32'(gidx), 32'(idx));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_vld"}, 32'(gv), 32'd0);
        chk({tag, "_idx"}, 32'(gidx), 32'd0);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk_idle("rst");
        tick();
        req   = '0;
        stall = 1'b0;
        rst_n = 1'b1;
    endtask

    int seq [16] = '{0, 4, 8, 12, 1, 5, 9, 13,
                     2, 6, 10, 14, 3, 7, 11, 15};

    initial begin
        rst_n = 1'b1;
        req   = 16'hFFFF;
        stall = 1'b0;
        tick();

        // Reset with everything requesting, then idle.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_idle("idle");
        end

        // Full contention from reset pointers.
        req = 16'hFFFF;
        for (int c = 0; c < 16; c++) begin
            tick();
            chk_grant("full", seq[c]);
        end
        tick();
        chk_grant("full_wrap", 0);

        // Lone persistent requester toggles valid.
        do_reset();
        req = 16'h0020;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c % 2 == 0) chk_grant("lone", 5);
            else            chk_idle("lone_off");
        end

        // Stall freezes the grant even as requests change.
        do_reset();
        req = 16'h0008;
        tick();
        chk_grant("st_pre", 3);
        stall = 1'b1;
        req   = 16'h8000;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_grant("st_hold", 3);
        end
        stall = 1'b0;
        tick();
        chk_grant("st_rel", 15);

        // Stall with no grant still blocks a new one.
        do_reset();
        stall = 1'b1;
        req   = 16'h0100;
        tick();
        chk_idle("st_idle");
        stall = 1'b0;
        tick();
        chk_grant("st_idle_rel", 8);

        // Two requesters in one group alternate every cycle.
        do_reset();
        req = 16'h0003;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk_grant("loc", c % 2);
        end

        // Async reset while a grant is frozen by stall.
        do_reset();
        req = 16'h0400;
        tick();
        chk_grant("ar_pre", 10);
        stall = 1'b1;
        tick();
        chk_grant("ar_stall", 10);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("ar_async");
        #2;
        rst_n = 1'b1;
        stall = 1'b0;
        req   = 16'hFFFF;
        tick();
        chk_grant("ar_first", 0);
        tick();
        chk_grant("ar_second", 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want done");
        $fatal(1);
    end

endmodule
